// File: rtl/wb_exc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// wb_exc_ctrl_pkg
//   Shared CPU definitions used by the write-back exception controller and the
//   CP0 register file it feeds:
//     virt_t            32-bit virtual address
//     exception_t       {ex, bd, exccode, badvaddr} carried down the pipeline
//     ws_to_c0_bus_t    {eret_flush, exception, wb_pc} presented to CP0
//     wb_exc_state_t    controller FSM state (IDLE, FLUSH, DRAIN)
//   Also provides the exception codes used by the controller and a helper
//   that builds the exception record handed to CP0.
// -----------------------------------------------------------------------------
package wb_exc_ctrl_pkg;

    typedef logic [31:0] virt_t;

    typedef struct packed {
        logic       ex;
        logic       bd;
        logic [4:0] exccode;
        virt_t      badvaddr;
    } exception_t;

    typedef struct packed {
        logic       eret_flush;
        exception_t exception;
        virt_t      wb_pc;
    } ws_to_c0_bus_t;

    // MIPS32 exception codes seen by this stage
    localparam logic [4:0] EXCCODE_INT  = 5'h00;
    localparam logic [4:0] EXCCODE_ADEL = 5'h04;
    localparam logic [4:0] EXCCODE_ADES = 5'h05;
    localparam logic [4:0] EXCCODE_SYS  = 5'h08;
    localparam logic [4:0] EXCCODE_BP   = 5'h09;
    localparam logic [4:0] EXCCODE_RI   = 5'h0a;
    localparam logic [4:0] EXCCODE_OV   = 5'h0c;

    // FSM encodings kept as plain constants so older code can compare raw bits
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        FLUSH = ST_FLUSH,
        DRAIN = ST_DRAIN
    } wb_exc_state_t;

    // Builds the exception record for CP0. An interrupt reports EXCCODE_INT and
    // no bad address; a taken exception forwards the upstream code/address.
    // The bd flag always reflects the WB instruction's own delay-slot status.
    function automatic exception_t make_c0_exception(
        input logic       take_int,
        input logic       take_exc,
        input logic       wb_bd,
        input exception_t upstream
    );
        exception_t rec;
        rec.ex       = take_int | take_exc;
        rec.bd       = wb_bd;
        rec.exccode  = take_int ? EXCCODE_INT : upstream.exccode;
        rec.badvaddr = take_exc ? upstream.badvaddr : 32'h0000_0000;
        return rec;
    endfunction

endpackage : wb_exc_ctrl_pkg

// File: rtl/wb_exc_ctrl.sv
// -----------------------------------------------------------------------------
// wb_exc_ctrl
//   Write-back-stage exception / interrupt controller sitting directly in front
//   of CP0. For the instruction in WB it arbitrates interrupts, pipeline
//   exceptions and ERET (in that priority), builds the CP0 bus, gates commit,
//   and issues a one-cycle flush with a redirect target. After the flush a
//   drain window squashes stale instructions until the refetched stream
//   arrives in WB.
//
// Ports:
//   clk           in   clock
//   resetn        in   asynchronous active-low reset
//   ws_valid      in   WB holds a valid instruction
//   ws_pc         in   PC of the WB instruction
//   ws_bd         in   WB instruction sits in a branch delay slot
//   ws_exc_in     in   exception collected upstream (its bd field is ignored)
//   ws_eret       in   WB instruction is ERET
//   c0_hw         in   masked hardware interrupt requests
//   c0_sw         in   masked software interrupt requests
//   epc           in   current CP0 EPC
//   ws_to_c0_bus  out  {eret_flush, exception, wb_pc} to CP0 (combinational)
//   ws_commit     out  WB instruction may update regfile / CP0
//   flush         out  one-cycle flush pulse
//   flush_target  out  redirect PC, valid while flush=1
//   exc_busy      out  controller is flushing or draining
// -----------------------------------------------------------------------------
module wb_exc_ctrl
    import wb_exc_ctrl_pkg::*;
#(
    parameter virt_t       EXC_VECTOR   = 32'hBFC0_0380,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          ws_valid,
    input  virt_t         ws_pc,
    input  logic          ws_bd,
    input  exception_t    ws_exc_in,
    input  logic          ws_eret,
    input  logic [5:0]    c0_hw,
    input  logic [1:0]    c0_sw,
    input  virt_t         epc,
    output ws_to_c0_bus_t ws_to_c0_bus,
    output logic          ws_commit,
    output logic          flush,
    output virt_t         flush_target,
    output logic          exc_busy
);

    // Out-of-range drain lengths are clamped into the 1..15 window the 4-bit
    // counter can represent.
    localparam int unsigned DRAIN_LEN  = (DRAIN_CYCLES < 1)  ? 1  :
                                         (DRAIN_CYCLES > 15) ? 15 : DRAIN_CYCLES;
    localparam logic [3:0]  DRAIN_LOAD = 4'(DRAIN_LEN - 1);

    wb_exc_state_t state_q, state_d;
    logic [3:0]    drain_cnt_q, drain_cnt_d;
    virt_t         target_q, target_d;
    logic          int_q, int_d;
    logic          flush_q, flush_d;
    logic          busy_q, busy_d;

    logic          event_window_s;
    logic          take_int_s;
    logic          take_exc_s;
    logic          take_eret_s;
    logic          any_take_s;

    // The upstream bd bit is superseded by ws_bd.
    logic          unused_bd_s;
    assign unused_bd_s = ws_exc_in.bd;

    // Interrupt request level, registered once per cycle
    always_comb begin
        int_d = |{c0_hw, c0_sw};
    end

    // Event arbitration: only an IDLE controller with a valid WB instruction
    // may take anything. resetn is folded in so nothing commits or traps
    // while reset is held.
    always_comb begin
        event_window_s = 1'b0;
        if (resetn && (state_q == IDLE) && ws_valid) begin
            event_window_s = 1'b1;
        end else begin
            event_window_s = 1'b0;
        end
        take_int_s  = event_window_s & int_q;
        take_exc_s  = event_window_s & ~int_q & ws_exc_in.ex;
        take_eret_s = event_window_s & ~int_q & ~ws_exc_in.ex & ws_eret;
        any_take_s  = take_int_s | take_exc_s | take_eret_s;
    end

    // CP0 bus and commit gate, sampled by CP0 at the same edge as the event
    always_comb begin
        ws_to_c0_bus.eret_flush = take_eret_s;
        ws_to_c0_bus.exception  = make_c0_exception(take_int_s, take_exc_s,
                                                    ws_bd, ws_exc_in);
        ws_to_c0_bus.wb_pc      = ws_pc;
        ws_commit               = event_window_s & ~any_take_s;
    end

    // FSM next state, drain counter and redirect target
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        target_d    = target_q;
        case (state_q)
            IDLE: begin
                if (any_take_s) begin
                    state_d = FLUSH;
                    // ERET returns to the EPC visible in the event cycle
                    target_d = take_eret_s ? epc : EXC_VECTOR;
                end else begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                state_d     = DRAIN;
                drain_cnt_d = DRAIN_LOAD;
            end
            DRAIN: begin
                if (drain_cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d     = IDLE;
                drain_cnt_d = 4'd0;
            end
        endcase
    end

    // Output flags decoded from the next state so they leave a flop
    always_comb begin
        flush_d = (state_d == FLUSH);
        busy_d  = (state_d != IDLE);
    end

    // State registers with asynchronous reset; reset aborts any flush/drain
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            drain_cnt_q <= 4'd0;
            target_q    <= EXC_VECTOR;
            int_q       <= 1'b0;
            flush_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            target_q    <= target_d;
            int_q       <= int_d;
            flush_q     <= flush_d;
            busy_q      <= busy_d;
        end
    end

    assign flush        = flush_q;
    assign flush_target = target_q;
    assign exc_busy     = busy_q;

endmodule : wb_exc_ctrl

// File: tb/tb_wb_exc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wb_exc_ctrl
//   Directed bench for wb_exc_ctrl. Inputs change just after the falling edge
//   and outputs are sampled 1 time unit later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_wb_exc_ctrl;
    import wb_exc_ctrl_pkg::*;

    logic          clk;
    logic          resetn;
    logic          ws_valid;
    virt_t         ws_pc;
    logic          ws_bd;
    exception_t    ws_exc_in;
    logic          ws_eret;
    logic [5:0]    c0_hw;
    logic [1:0]    c0_sw;
    virt_t         epc;
    ws_to_c0_bus_t ws_to_c0_bus;
    logic          ws_commit;
    logic          flush;
    virt_t         flush_target;
    logic          exc_busy;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    int busy_len;

    wb_exc_ctrl #(
        .EXC_VECTOR  (32'hBFC0_0380),
        .DRAIN_CYCLES(4)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .ws_valid    (ws_valid),
        .ws_pc       (ws_pc),
        .ws_bd       (ws_bd),
        .ws_exc_in   (ws_exc_in),
        .ws_eret     (ws_eret),
        .c0_hw       (c0_hw),
        .c0_sw       (c0_sw),
        .epc         (epc),
        .ws_to_c0_bus(ws_to_c0_bus),
        .ws_commit   (ws_commit),
        .flush       (flush),
        .flush_target(flush_target),
        .exc_busy    (exc_busy)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        ws_valid  = 1'b0;
        ws_pc     = 32'h0000_0000;
        ws_bd     = 1'b0;
        ws_exc_in = '0;
        ws_eret   = 1'b0;
        c0_hw     = 6'd0;
        c0_sw     = 2'd0;
    endtask

    // Step to the next sampling point (falling edge + 1)
    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    // Wait (bounded) until the controller is back in IDLE
    task automatic wait_idle(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (!exc_busy) break;
            next_cycle();
        end
        chk(tag, {31'd0, exc_busy}, 32'd0);
    endtask

    initial begin
        clear_inputs();
        epc      = 32'h0000_0000;
        resetn   = 1'b0;
        ws_valid = 1'b1;
        ws_pc    = 32'hBFC0_0010;

        // ---- reset state (valid held high: commit must still be 0) ----
        #2;
        chk("rst_flush",  {31'd0, flush},     32'd0);
        chk("rst_busy",   {31'd0, exc_busy},  32'd0);
        chk("rst_commit", {31'd0, ws_commit}, 32'd0);
        next_cycle();
        chk("rst_target", flush_target, 32'hBFC0_0380);

        // ---- plain commit in IDLE ----
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("idle_commit", {31'd0, ws_commit}, 32'd1);
        chk("idle_ex",     {31'd0, ws_to_c0_bus.exception.ex}, 32'd0);
        chk("idle_pc",     ws_to_c0_bus.wb_pc, 32'hBFC0_0010);
        next_cycle();
        chk("idle_flush",  {31'd0, flush},     32'd0);
        chk("idle_commit2",{31'd0, ws_commit}, 32'd1);

        // ---- interrupt: one-cycle request, taken by the next valid instr ----
        ws_valid = 1'b0;
        c0_hw    = 6'b000001;
        next_cycle();
        c0_hw    = 6'd0;
        ws_valid = 1'b1;
        ws_pc    = 32'hBFC0_0100;
        ws_bd    = 1'b0;
        #1;
        chk("int_ex",      {31'd0, ws_to_c0_bus.exception.ex}, 32'd1);
        chk("int_code",    {27'd0, ws_to_c0_bus.exception.exccode}, 32'd0);
        chk("int_commit",  {31'd0, ws_commit}, 32'd0);
        chk("int_flush_e", {31'd0, flush}, 32'd0);
        next_cycle();
        ws_valid = 1'b0;
        #1;
        chk("int_flush",   {31'd0, flush}, 32'd1);
        chk("int_target",  flush_target, 32'hBFC0_0380);
        busy_len = 0;
        for (int i = 0; i < 20; i++) begin
            if (!exc_busy) break;
            busy_len++;
            next_cycle();
        end
        chk("int_busy_len", busy_len, 32'd5);

        // ---- exception in delay slot, stale exceptions during drain ----
        ws_valid  = 1'b1;
        ws_pc     = 32'hBFC0_0104;
        ws_bd     = 1'b1;
        ws_exc_in = '{ex: 1'b1, bd: 1'b0, exccode: EXCCODE_ADEL, badvaddr: 32'h0000_0003};
        #1;
        chk("exc_ex",     {31'd0, ws_to_c0_bus.exception.ex}, 32'd1);
        chk("exc_bd",     {31'd0, ws_to_c0_bus.exception.bd}, 32'd1);
        chk("exc_code",   {27'd0, ws_to_c0_bus.exception.exccode}, 32'd4);
        chk("exc_bva",    ws_to_c0_bus.exception.badvaddr, 32'h0000_0003);
        chk("exc_commit", {31'd0, ws_commit}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            ws_bd = 1'b0;
            ws_pc = 32'hBFC0_0108 + 32'(i * 4);
            #1;
            if (i == 0) begin
                chk("exc_flush",  {31'd0, flush}, 32'd1);
                chk("exc_target", flush_target, 32'hBFC0_0380);
            end else begin
                chk("drain_flush", {31'd0, flush}, 32'd0);
            end
            chk("drain_ex",     {31'd0, ws_to_c0_bus.exception.ex}, 32'd0);
            chk("drain_commit", {31'd0, ws_commit}, 32'd0);
            chk("drain_busy",   {31'd0, exc_busy}, 32'd1);
        end
        next_cycle();
        ws_exc_in = '0;
        #1;
        chk("post_drain_commit", {31'd0, ws_commit}, 32'd1);
        chk("post_drain_busy",   {31'd0, exc_busy}, 32'd0);

        // ---- interrupt and exception together: interrupt wins ----
        next_cycle();
        ws_valid  = 1'b0;
        c0_sw     = 2'b01;
        ws_exc_in = '{ex: 1'b1, bd: 1'b0, exccode: EXCCODE_ADEL, badvaddr: 32'h0000_0003};
        next_cycle();
        c0_sw    = 2'd0;
        ws_valid = 1'b1;
        ws_bd    = 1'b1;
        #1;
        chk("ie_ex",   {31'd0, ws_to_c0_bus.exception.ex}, 32'd1);
        chk("ie_code", {27'd0, ws_to_c0_bus.exception.exccode}, 32'd0);
        chk("ie_bva",  ws_to_c0_bus.exception.badvaddr, 32'd0);
        next_cycle();
        clear_inputs();
        #1;
        chk("ie_target", flush_target, 32'hBFC0_0380);
        wait_idle("ie_idle");

        // ---- ERET: redirect uses the EPC of the event cycle ----
        ws_valid = 1'b1;
        ws_eret  = 1'b1;
        epc      = 32'hBFC0_0200;
        #1;
        chk("eret_flag",   {31'd0, ws_to_c0_bus.eret_flush}, 32'd1);
        chk("eret_ex",     {31'd0, ws_to_c0_bus.exception.ex}, 32'd0);
        chk("eret_commit", {31'd0, ws_commit}, 32'd0);
        next_cycle();
        clear_inputs();
        epc = 32'h1234_5678;
        #1;
        chk("eret_flush",  {31'd0, flush}, 32'd1);
        chk("eret_target", flush_target, 32'hBFC0_0200);
        wait_idle("eret_idle");

        // ---- exception and ERET together: exception wins ----
        ws_valid  = 1'b1;
        ws_eret   = 1'b1;
        ws_exc_in = '{ex: 1'b1, bd: 1'b0, exccode: EXCCODE_SYS, badvaddr: 32'h0000_DEAD};
        #1;
        chk("ee_ex",   {31'd0, ws_to_c0_bus.exception.ex}, 32'd1);
        chk("ee_eret", {31'd0, ws_to_c0_bus.eret_flush}, 32'd0);
        chk("ee_code", {27'd0, ws_to_c0_bus.exception.exccode}, 32'd8);
        next_cycle();
        clear_inputs();
        #1;
        chk("ee_target", flush_target, 32'hBFC0_0380);
        wait_idle("ee_idle");

        // ---- interrupt request gone before a valid instruction: not taken ----
        c0_hw = 6'b100000;
        next_cycle();
        c0_hw = 6'd0;
        next_cycle();
        ws_valid = 1'b1;
        ws_pc    = 32'hBFC0_0300;
        #1;
        chk("lvl_commit", {31'd0, ws_commit}, 32'd1);
        chk("lvl_ex",     {31'd0, ws_to_c0_bus.exception.ex}, 32'd0);
        next_cycle();
        chk("lvl_flush",  {31'd0, flush}, 32'd0);
        chk("lvl_busy",   {31'd0, exc_busy}, 32'd0);

        // ---- reset asserted during FLUSH aborts immediately ----
        ws_exc_in = '{ex: 1'b1, bd: 1'b0, exccode: EXCCODE_ADES, badvaddr: 32'h0000_0010};
        #1;
        chk("rf_ex", {31'd0, ws_to_c0_bus.exception.ex}, 32'd1);
        next_cycle();
        clear_inputs();
        #1;
        chk("rf_flush_pre", {31'd0, flush}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("rf_flush_drop", {31'd0, flush}, 32'd0);
        chk("rf_busy_drop",  {31'd0, exc_busy}, 32'd0);
        next_cycle();
        resetn = 1'b1;
        next_cycle();
        ws_valid = 1'b1;
        ws_eret  = 1'b1;
        epc      = 32'hBFC0_0300;
        #1;
        chk("rf_eret_flag", {31'd0, ws_to_c0_bus.eret_flush}, 32'd1);
        next_cycle();
        clear_inputs();
        #1;
        chk("rf_eret_flush",  {31'd0, flush}, 32'd1);
        chk("rf_eret_target", flush_target, 32'hBFC0_0300);
        wait_idle("rf_idle");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_wb_exc_ctrl

// File: doc/wb_exc_ctrl.md
Name: wb_exc_ctrl

Overview:
- Write-back-stage exception and interrupt controller. It sits directly upstream of the CP0 register file.
- Arbitrates three event sources for the instruction currently in WB: pending interrupts from CP0, exceptions carried down the pipeline, and ERET.
- Builds the ws_to_c0_bus for CP0, gates architectural commit, and drives the pipeline flush and redirect toward fetch.
- After a flush, a drain FSM suppresses stale instructions until the refetched stream reaches WB.

Parameters:
- EXC_VECTOR, 32'hBFC00380: redirect target for exceptions and interrupts (BEV=1).
- DRAIN_CYCLES, 4: cycles after the flush pulse during which WB instructions are squashed; legal range 1..15.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- ws_valid  in  1  WB holds a valid instruction this cycle.
- ws_pc  in  virt_t  PC of the WB instruction.
- ws_bd  in  1  WB instruction is in a branch delay slot.
- ws_exc_in  in  exception_t  exception collected upstream (ex, exccode, badvaddr); its bd field is ignored.
- ws_eret  in  1  WB instruction is ERET.
- c0_hw  in  6  masked hardware interrupt requests from CP0.
- c0_sw  in  2  masked software interrupt requests from CP0.
- epc  in  virt_t  current CP0 EPC.
- ws_to_c0_bus  out  ws_to_c0_bus_t  {eret_flush, exception, wb_pc} to CP0.
- ws_commit  out  1  WB instruction may write the regfile or CP0.
- flush  out  1  one-cycle pipeline flush pulse.
- flush_target  out  virt_t  redirect PC; valid while flush=1.
- exc_busy  out  1  FSM is not in IDLE.

Behaviour:
- Interrupt sampling:
  - int_q <= |{c0_hw, c0_sw} every cycle.
  - Interrupts are level-sensitive: if the request drops before a valid WB instruction arrives, nothing is taken.
- Event detection, combinational, only when state==IDLE && ws_valid. Priority order:
  - int_q, then ws_exc_in.ex, then ws_eret.
  - take_int = int_q.
  - take_exc = !int_q && ws_exc_in.ex.
  - take_eret = !int_q && !ws_exc_in.ex && ws_eret.
- ws_to_c0_bus is combinational, so CP0 samples it at the same clock edge:
  - exception.ex = take_int | take_exc.
  - exccode = take_int ? 5'h00 : ws_exc_in.exccode.
  - badvaddr = take_exc ? ws_exc_in.badvaddr : 0.
  - exception.bd = ws_bd.
  - eret_flush = take_eret.
  - wb_pc = ws_pc.
  - Outside the IDLE && ws_valid condition, ex and eret_flush are 0.
- ws_commit = state==IDLE && ws_valid && !(take_int | take_exc | take_eret).
- FSM states and transitions:
  - IDLE: any take_* moves to FLUSH. The target register is loaded in the same edge: EXC_VECTOR for int/exc, epc for eret.
  - FLUSH: lasts exactly 1 cycle; flush=1, flush_target=target register. Loads drain_cnt=DRAIN_CYCLES-1 and moves to DRAIN.
  - DRAIN: ws_commit=0 and no events are taken. drain_cnt decrements each cycle; drain_cnt==0 moves to IDLE.
- Latency:
  - Event edge to flush=1: 1 cycle.
  - Total non-IDLE time: 1+DRAIN_CYCLES cycles.
  - exc_busy = state!=IDLE.
- Simultaneous events:
  - Interrupt together with an exception: the interrupt wins (exccode 0) and the faulting instruction is re-executed later.
  - Exception together with ERET: the exception wins.
- ERET redirect uses the epc value present in the event cycle. An MTC0 EPC one instruction earlier is already visible at that point.
- Events arriving while in FLUSH or DRAIN are dropped. The pipeline is refetching, so those instructions are stale.
- Reset values, asynchronous, applied mid-operation too:
  - state=IDLE, int_q=0, drain_cnt=0, target=EXC_VECTOR.
  - flush=0, exc_busy=0, ws_commit=0.
  - Reset during FLUSH or DRAIN aborts immediately.

Decomposition:
- Shared cpu_defs package:
  - exception_t, ws_to_c0_bus_t, virt_t.
  - EXCCODE_INT (5'h00).
  - A state enum wb_exc_state_t {IDLE, FLUSH, DRAIN}.
- No sub-module: the drain counter and FSM are kept inline.

Test Plan:
- Reset, then IDLE with ws_valid=1, no events, pc=0xBFC00010 -> ws_commit=1, flush never asserts, ex=0.
- c0_hw=6'b000001 for 1 cycle, then ws_valid with pc=0xBFC00100, bd=0:
  - Event cycle: ex=1, exccode=0, ws_commit=0.
  - Next cycle: flush=1, flush_target=0xBFC00380.
  - exc_busy stays high for 5 cycles.
- ws_exc_in={ex=1, exccode=ADEL, badvaddr=0x00000003} with ws_bd=1 -> ex=1, bd=1, badvaddr=0x3. The same cycle with int_q=1 instead gives exccode=0, badvaddr=0.
- ERET with epc=0xBFC00200 -> eret_flush=1, ex=0. Next cycle: flush=1, target=0xBFC00200.
- Exception followed by ws_valid with ex=1 for each of the next 4 cycles -> none of them taken, ws_commit=0 throughout. The first valid instruction after DRAIN commits.
- Assert resetn=0 in the FLUSH cycle -> flush drops asynchronously, state=IDLE. After release, the next event behaves normally.
